// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin ownership of the shared system bus between MASTERS
// requesters, with a watchdog that aborts cycles no device ever completes.
module bus_arbiter #(
  parameter int MASTERS = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [32*MASTERS-1:0]   m_addr,
  input  logic [32*MASTERS-1:0]   m_wdata,
  input  logic [4*MASTERS-1:0]    m_mask,
  input  logic [MASTERS-1:0]      m_rd,
  input  logic [MASTERS-1:0]      m_wr,
  output logic [31:0]             m_rdata,
  output logic [MASTERS-1:0]      m_fc,
  output logic [MASTERS-1:0]      m_err,
  output logic                    grant_valid,
  output logic [2:0]              grant_idx,
  output logic [31:0]             addr_bus,
  inout  wire  [31:0]             data_bus,
  output logic                    rd_bus,
  output logic                    wr_bus,
  output logic [3:0]              data_mask_bus,
  input  logic                    fc_bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         last_q, last_d;
  logic [15:0]        wdog_q, wdog_d, wdog_inc_s;
  logic [MASTERS-1:0] req_s, sel_s;
  logic [31:0]        g_addr_s, g_wdata_s;
  logic [3:0]         g_mask_s;
  logic               g_rd_s, g_wr_s;
  logic               found_s;
  logic [2:0]         winner_s;
  logic               owned_s, abort_s, fc_s;

  assign req_s   = m_rd | m_wr;
  assign owned_s = (state_q == OWNED);
  assign abort_s = (state_q == ABORT);
  assign fc_s    = fc_bus;

  // Owner's request fields, AND-OR selected by the registered grant index
  always_comb begin
    sel_s     = {MASTERS{1'b0}};
    g_addr_s  = 32'd0;
    g_wdata_s = 32'd0;
    g_mask_s  = 4'd0;
    g_rd_s    = 1'b0;
    g_wr_s    = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      sel_s[i]  = (grant_q == 3'(i));
      g_addr_s  = g_addr_s  | (m_addr[32*i +: 32]  & {32{sel_s[i]}});
      g_wdata_s = g_wdata_s | (m_wdata[32*i +: 32] & {32{sel_s[i]}});
      g_mask_s  = g_mask_s  | (m_mask[4*i +: 4]    & {4{sel_s[i]}});
      g_rd_s    = g_rd_s    | (m_rd[i] & sel_s[i]);
      g_wr_s    = g_wr_s    | (m_wr[i] & sel_s[i]);
    end
  end

  // Rotating search: first requester after the previous owner wins
  always_comb begin
    found_s  = 1'b0;
    winner_s = 3'd0;
    for (int k = 1; k <= MASTERS; k++) begin
      for (int j = 0; j < MASTERS; j++) begin
        if (!found_s && req_s[j] && (j == (int'(last_q) + k) % MASTERS)) begin
          found_s  = 1'b1;
          winner_s = 3'(j);
        end else begin
          winner_s = winner_s;
        end
      end
    end
  end

  assign wdog_inc_s = (wdog_q == 16'hFFFF) ? wdog_q : (wdog_q + 16'd1);

  // Next-state logic; release is tested before timeout and illegal strobes
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = OWNED;
          grant_d = winner_s;
          wdog_d  = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        wdog_d = fc_s ? 16'd0 : wdog_inc_s;
        if (!g_rd_s && !g_wr_s) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (g_rd_s && g_wr_s) begin
          state_d = ABORT;
        end else if (!fc_s && (wdog_inc_s >= 16'(TIMEOUT))) begin
          state_d = ABORT;
        end else begin
          state_d = OWNED;
        end
      end
      ABORT: begin
        if (!g_rd_s && !g_wr_s) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else begin
          state_d = ABORT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, owner, rotation pointer and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 3'd0;
      last_q  <= 3'(MASTERS - 1);
      wdog_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  // Bus side follows the owner combinationally; strobes only in OWNED
  assign grant_valid   = owned_s | abort_s;
  assign grant_idx     = grant_valid ? grant_q : 3'd0;
  assign addr_bus      = grant_valid ? g_addr_s : 32'd0;
  assign data_mask_bus = grant_valid ? g_mask_s : 4'd0;
  assign rd_bus        = owned_s & g_rd_s & ~g_wr_s;
  assign wr_bus        = owned_s & g_wr_s & ~g_rd_s;
  assign data_bus      = wr_bus ? g_wdata_s : {32{1'bz}};

  assign m_rdata = (owned_s & g_rd_s) ? data_bus : 32'd0;
  assign m_fc    = sel_s & {MASTERS{(owned_s & fc_s) | abort_s}};
  assign m_err   = sel_s & {MASTERS{abort_s}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (2 masters, TIMEOUT=4); expected grant
// order is queued as requests are raised and popped when a grant appears.
module tb_bus_arbiter;

  localparam int M  = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   m_addr, m_wdata;
  logic [7:0]    m_mask;
  logic [1:0]    m_rd, m_wr;
  logic [31:0]   m_rdata;
  logic [1:0]    m_fc, m_err;
  logic          grant_valid;
  logic [2:0]    grant_idx;
  logic [31:0]   addr_bus;
  wire  [31:0]   data_bus;
  logic          rd_bus, wr_bus;
  logic [3:0]    data_mask_bus;
  logic          fc_bus;
  logic          dev_oe;
  logic [31:0]   dev_data;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int exp_g;
  int cyc;
  logic strobe_seen;

  assign data_bus = dev_oe ? dev_data : 32'hzzzz_zzzz;

  bus_arbiter #(.MASTERS(M), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_fc(m_fc), .m_err(m_err),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .addr_bus(addr_bus), .data_bus(data_bus),
    .rd_bus(rd_bus), .wr_bus(wr_bus),
    .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Waits (bounded) for grant_valid at a negedge; n = extra cycles beyond one
  task automatic wait_grant(output int n);
    n = 0;
    @(negedge clk);
    while (grant_valid !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) exp_g = exp_q.pop_front();
    else exp_g = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_addr = 64'd0; m_wdata = 64'd0; m_mask = 8'd0;
    m_rd = 2'b00; m_wr = 2'b00; fc_bus = 1'b0; dev_oe = 1'b0; dev_data = 32'd0;
    repeat (2) @(negedge clk);
    tests++; if ({grant_valid, rd_bus, wr_bus, grant_idx, m_fc, m_err} !== 10'd0) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=0", {grant_valid, rd_bus, wr_bus, grant_idx, m_fc, m_err}); end
    tests++; if ({addr_bus, data_mask_bus, m_rdata} !== 68'd0) begin
      fails++; $display("FAIL reset_bus got=%h exp=0", {addr_bus, data_mask_bus, m_rdata}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m_addr[31:0] = 32'h0000_1000; m_wdata[31:0] = 32'h0000_00A5; m_mask[3:0] = 4'h1;
    m_wr[0] = 1'b1; exp_q.push_back(0);
    #1;
    tests++; if (wr_bus !== 1'b0) begin fails++; $display("FAIL wr_early got=%b exp=0", wr_bus); end
    wait_grant(cyc);
    tests++; if (cyc !== 0) begin fails++; $display("FAIL wr_latency got=%0d exp=0", cyc); end
    pop_exp();
    tests++; if (grant_idx !== 3'(exp_g)) begin fails++; $display("FAIL wr_grant got=%0d exp=%0d", grant_idx, exp_g); end
    tests++; if ({wr_bus, rd_bus, addr_bus, data_mask_bus} !== {1'b1, 1'b0, 32'h0000_1000, 4'h1}) begin
      fails++; $display("FAIL wr_bus_fields got=%h", {wr_bus, rd_bus, addr_bus, data_mask_bus}); end
    tests++; if (data_bus !== 32'h0000_00A5) begin fails++; $display("FAIL wr_data got=%h exp=000000a5", data_bus); end
    tests++; if (m_fc !== 2'b00) begin fails++; $display("FAIL wr_fc_low got=%b exp=00", m_fc); end
    @(negedge clk);
    fc_bus = 1'b1;
    #1;
    tests++; if (m_fc !== 2'b01) begin fails++; $display("FAIL wr_fc_high got=%b exp=01", m_fc); end
    @(negedge clk);
    fc_bus = 1'b0; m_wr[0] = 1'b0;
    #1;
    tests++; if (wr_bus !== 1'b0) begin fails++; $display("FAIL wr_release_strobe got=%b exp=0", wr_bus); end
    @(negedge clk);
    tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL wr_idle got=%b exp=0", grant_valid); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_addr = {32'h0000_0104, 32'h0000_0100};
    m_wdata = {32'h1111_1111, 32'h0000_0000};
    m_wr = 2'b11;
    for (int t = 0; t < 4; t++) exp_q.push_back(t % 2);
    for (int t = 0; t < 4; t++) begin
      wait_grant(cyc);
      tests++; if (cyc !== 0) begin fails++; $display("FAIL ct_latency[%0d] got=%0d exp=0", t, cyc); end
      pop_exp();
      tests++; if (grant_idx !== 3'(exp_g)) begin fails++; $display("FAIL ct_order[%0d] got=%0d exp=%0d", t, grant_idx, exp_g); end
      tests++; if (addr_bus !== 32'h0000_0100 + 32'(4 * exp_g)) begin
        fails++; $display("FAIL ct_addr[%0d] got=%h", t, addr_bus); end
      fc_bus = 1'b1;
      @(negedge clk);
      fc_bus = 1'b0;
      m_wr = m_wr & ~(2'b01 << exp_g);
      @(negedge clk);
      tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL ct_gap[%0d] got=%b exp=0", t, grant_valid); end
      if (t < 3) m_wr = 2'b11;
      else m_wr = 2'b00;
    end
  endtask

  task automatic test_read_return();
    m_addr[63:32] = 32'h0000_2000; m_rd[1] = 1'b1; exp_q.push_back(1);
    wait_grant(cyc);
    tests++; if (cyc !== 0) begin fails++; $display("FAIL rd_latency got=%0d exp=0", cyc); end
    pop_exp();
    tests++; if (grant_idx !== 3'(exp_g)) begin fails++; $display("FAIL rd_grant got=%0d exp=%0d", grant_idx, exp_g); end
    tests++; if ({rd_bus, wr_bus, m_fc} !== 4'b1000) begin fails++; $display("FAIL rd_strobe got=%b exp=1000", {rd_bus, wr_bus, m_fc}); end
    dev_oe = 1'b1; dev_data = 32'hDEAD_BEEF; fc_bus = 1'b1;
    #1;
    tests++; if (m_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", m_rdata); end
    tests++; if (m_fc !== 2'b10) begin fails++; $display("FAIL rd_fc got=%b exp=10", m_fc); end
    @(negedge clk);
    dev_oe = 1'b0; fc_bus = 1'b0; m_rd[1] = 1'b0;
    #1;
    tests++; if ({m_rdata, m_fc} !== 34'd0) begin fails++; $display("FAIL rd_release got=%h exp=0", {m_rdata, m_fc}); end
    @(negedge clk);
    tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL rd_idle got=%b exp=0", grant_valid); end
  endtask

  task automatic test_timeout();
    m_addr[31:0] = 32'hF000_0000; m_rd[0] = 1'b1; exp_q.push_back(0);
    wait_grant(cyc);
    tests++; if (cyc !== 0) begin fails++; $display("FAIL to_latency got=%0d exp=0", cyc); end
    pop_exp();
    tests++; if (grant_idx !== 3'(exp_g)) begin fails++; $display("FAIL to_grant got=%0d exp=%0d", grant_idx, exp_g); end
    for (int c = 1; c <= TO; c++) begin
      if (c > 1) @(negedge clk);
      tests++; if (rd_bus !== 1'b1) begin fails++; $display("FAIL to_owned[%0d] rd_bus got=%b exp=1", c, rd_bus); end
    end
    @(negedge clk);
    tests++; if ({grant_valid, rd_bus, m_err, m_fc} !== 6'b100101) begin
      fails++; $display("FAIL to_abort got=%b exp=100101", {grant_valid, rd_bus, m_err, m_fc}); end
    @(negedge clk);
    m_rd[0] = 1'b0;
    #1;
    tests++; if ({m_err, m_fc} !== 4'b0101) begin fails++; $display("FAIL to_hold got=%b exp=0101", {m_err, m_fc}); end
    @(negedge clk);
    tests++; if ({grant_valid, m_err} !== 3'b000) begin fails++; $display("FAIL to_idle got=%b exp=000", {grant_valid, m_err}); end
  endtask

  task automatic test_illegal();
    m_rd[0] = 1'b1; m_wr[0] = 1'b1; exp_q.push_back(0);
    #1;
    strobe_seen = rd_bus | wr_bus;
    wait_grant(cyc);
    strobe_seen = strobe_seen | rd_bus | wr_bus;
    pop_exp();
    tests++; if (grant_idx !== 3'(exp_g)) begin fails++; $display("FAIL il_grant got=%0d exp=%0d", grant_idx, exp_g); end
    tests++; if (m_err !== 2'b00) begin fails++; $display("FAIL il_err_early got=%b exp=00", m_err); end
    @(negedge clk);
    strobe_seen = strobe_seen | rd_bus | wr_bus;
    tests++; if ({m_err, m_fc} !== 4'b0101) begin fails++; $display("FAIL il_abort got=%b exp=0101", {m_err, m_fc}); end
    m_rd = 2'b00; m_wr = 2'b00;
    @(negedge clk);
    tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL il_idle got=%b exp=0", grant_valid); end
    tests++; if (strobe_seen !== 1'b0) begin fails++; $display("FAIL il_strobe got=%b exp=0", strobe_seen); end
  endtask

  task automatic test_reset_mid();
    m_addr[63:32] = 32'h0000_3000; m_wdata[63:32] = 32'h5A5A_5A5A; m_wr[1] = 1'b1;
    exp_q.push_back(1);
    wait_grant(cyc);
    pop_exp();
    tests++; if (grant_idx !== 3'(exp_g)) begin fails++; $display("FAIL rm_grant got=%0d exp=%0d", grant_idx, exp_g); end
    tests++; if (data_bus !== 32'h5A5A_5A5A) begin fails++; $display("FAIL rm_data got=%h exp=5a5a5a5a", data_bus); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({wr_bus, grant_valid} !== 2'b00) begin fails++; $display("FAIL rm_async got=%b exp=00", {wr_bus, grant_valid}); end
    tests++; if (data_bus === 32'h5A5A_5A5A) begin fails++; $display("FAIL rm_data_released got=%h exp=z", data_bus); end
    m_addr[31:0] = 32'h0000_4000; m_wr = 2'b11;
    @(negedge clk);
    rst_n = 1'b1; exp_q.push_back(0);
    wait_grant(cyc);
    tests++; if (cyc !== 0) begin fails++; $display("FAIL rm_latency got=%0d exp=0", cyc); end
    pop_exp();
    tests++; if (grant_idx !== 3'(exp_g)) begin fails++; $display("FAIL rm_first got=%0d exp=%0d", grant_idx, exp_g); end
    m_wr = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_read_return();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
